fft_ctrl: RTL



---
 rtl/fft_ctrl_pkg.sv | 16 +
 rtl/fft_ctrl_if.sv | 11 +
 rtl/fft_ctrl_timer.sv | 17 +
 rtl/fft_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state encoding, bus address map and register bit positions
package fft_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [6:0] SAMPLE_BASE = 7'h00;
    localparam logic [6:0] RESULT_BASE = 7'h20;
    localparam logic [6:0] CTRL_ADDR = 7'h40;
    localparam logic [6:0] STATUS_ADDR = 7'h41;
    localparam int CTRL_START = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_COUNT = 4;
endpackage

// File: rtl/fft_ctrl_if.sv
// fft_ctrl_if: word-addressed CPU bus between peripheral decode and fft_ctrl
interface fft_ctrl_if;
    logic en;
    logic we;
    logic [6:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic rvalid;
    modport master (output en, we, addr, wdata, input rdata, rvalid);
    modport slave (input en, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/fft_ctrl_timer.sv
// fft_ctrl_timer: clear/enable cycle counter, expire flags the TIMEOUT-th cycle
module fft_ctrl_timer #(
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign expire = cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: bus front-end and run sequencer for the 32-point FFT datapath.
// Define FFT_CTRL_AUTOSTART_EN to start the transform automatically on a full load.
module fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    fft_ctrl_if.slave bus,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic m_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic s_re,
    input logic [2*DATA_WIDTH-1:0] s_data,
    output logic fft_rst,
    input logic fft_done,
    output logic irq
);
    localparam int CW = $clog2(DEPTH + 1);
    state_t state, nxt;
    logic [CW-1:0] count;
    logic timeout, overrun, irq_en, done, expire, auto_go;
    logic is_sample, is_result, wr, rd, sample_wr, ctrl_wr, start, clear, accept;
    logic rsel, rvalid;
    logic [31:0] rreg, hold, status, ctrl_rd;
    logic unused;
    assign unused = ^bus.wdata[31:DATA_WIDTH];
    assign is_sample = bus.addr[6:5] == SAMPLE_BASE[6:5];
    assign is_result = bus.addr[6:5] == RESULT_BASE[6:5];
    assign wr = bus.en && bus.we;
    assign rd = bus.en && !bus.we;
    assign sample_wr = wr && is_sample;
    assign ctrl_wr = wr && bus.addr == CTRL_ADDR;
    assign start = ctrl_wr && bus.wdata[CTRL_START];
    assign clear = ctrl_wr && bus.wdata[CTRL_CLEAR];
    assign accept = sample_wr && state != RUN;
    assign done = state == DONE;
    assign fft_rst = state == IDLE || state == LOAD;
    assign irq = irq_en && done;
    assign s_addr = bus.addr[ADDR_WIDTH-1:0];
    assign s_re = rd && is_result;
`ifdef FFT_CTRL_AUTOSTART_EN
    assign auto_go = accept && state == LOAD && count == CW'(DEPTH - 1);
`else
    assign auto_go = 1'b0;
`endif
    fft_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state != RUN),
        .en(state == RUN),
        .expire(expire)
    );
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: nxt = accept ? LOAD : start ? RUN : IDLE;
            LOAD: nxt = (start || auto_go) ? RUN : LOAD;
            RUN: nxt = (fft_done || expire) ? DONE : RUN;
            DONE: nxt = accept ? LOAD : start ? RUN : DONE;
        endcase
        if (clear) nxt = IDLE;
    end
    always_comb begin
        status = '0;
        status[ST_BUSY] = state == RUN;
        status[ST_DONE] = done;
        status[ST_TIMEOUT] = timeout;
        status[ST_OVERRUN] = overrun;
        status[ST_COUNT +: CW] = count;
        ctrl_rd = '0;
        ctrl_rd[CTRL_IRQ_EN] = irq_en;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            timeout <= 1'b0;
            overrun <= 1'b0;
            irq_en <= 1'b0;
            m_we <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            rvalid <= 1'b0;
            rsel <= 1'b0;
            rreg <= '0;
            hold <= '0;
        end else begin
            state <= nxt;
            m_we <= accept;
            if (accept) begin
                m_addr <= bus.addr[ADDR_WIDTH-1:0];
                m_data <= bus.wdata[DATA_WIDTH-1:0];
            end
            if (ctrl_wr) irq_en <= bus.wdata[CTRL_IRQ_EN];
            if (clear) begin
                count <= '0;
                timeout <= 1'b0;
                overrun <= 1'b0;
            end else begin
                if (accept) count <= done ? CW'(1) : count == CW'(DEPTH) ? count : count + 1'b1;
                if (state == RUN && expire && !fft_done) timeout <= 1'b1;
                if (sample_wr && state == RUN) overrun <= 1'b1;
            end
            rvalid <= rd;
            if (rd) begin
                rsel <= is_result && done;
                rreg <= bus.addr == STATUS_ADDR ? status : bus.addr == CTRL_ADDR ? ctrl_rd : '0;
            end
            // Result data arrives from the slave file this cycle; latch it so it survives later cycles
            if (rvalid) hold <= bus.rdata;
        end
    end
    assign bus.rvalid = rvalid;
    assign bus.rdata = rvalid ? (rsel ? 32'(s_data) : rreg) : hold;
endmodule
